// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the irq_priority_ctrl block.
//  - irq_state_e : two-state handshake FSM encoding (IDLE, ASSERT)
//  - NCH_DEF / VEC_W_DEF : default channel count and vector width
//  - prio_res_t / prio_idx : lowest-set-bit search over a request vector
//    of up to PRIO_MAX_W bits, returning the index and a valid flag.
package irq_ctrl_pkg;

  localparam int NCH_DEF    = 9;
  localparam int VEC_W_DEF  = 4;
  localparam int PRIO_MAX_W = 32;
  localparam int PRIO_IDX_W = 5;

  typedef enum logic {
    IDLE   = 1'b0,
    ASSERT = 1'b1
  } irq_state_e;

  typedef struct packed {
    logic                  valid;
    logic [PRIO_IDX_W-1:0] idx;
  } prio_res_t;

  // Lowest index wins: scan from the top down so the last hit is the lowest.
  function automatic prio_res_t prio_idx(input logic [PRIO_MAX_W-1:0] vec);
    prio_res_t res;
    res = '0;
    for (int i = PRIO_MAX_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.valid = 1'b1;
        res.idx   = PRIO_IDX_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder, bit 0 highest priority.
// Ports:
//  req_i   [NCH-1:0]    request vector
//  valid_o              1 when any request bit is set
//  idx_o   [VEC_W-1:0]  index of the lowest set bit (0 when valid_o=0)
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic [NCH-1:0]   req_i,
  output logic             valid_o,
  output logic [VEC_W-1:0] idx_o
);

  prio_res_t res;

  always_comb begin
    res     = prio_idx(PRIO_MAX_W'(req_i));
    valid_o = res.valid;
    idx_o   = VEC_W'(res.idx);
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// 9-channel fixed-priority interrupt controller (channel 0 highest).
// Rising edges on irq_req set pending bits; enabled, gated pending bits are
// arbitrated and one vector at a time is presented to the CPU.
//
// Handshake: irq_out/vec_out act as valid/data, irq_ack as ready. A vector
// transfers at the rising edge where irq_out=1 and irq_ack=1; vec_out holds
// steady for as long as irq_out=1, and irq_out drops the cycle after transfer.
//
// Build option: define NESTING_EN to let strictly higher-priority channels
// preempt those in service. Without it only one channel is in service.
//
// Ports:
//  clk, rst_n            clock, synchronous active-low reset
//  irq_req  [NCH-1:0]    raw requests (edge-triggered, synchronous)
//  irq_en   [NCH-1:0]    per-channel arbitration enable
//  irq_ack               CPU accepts presented vector
//  eoi, eoi_id           end-of-interrupt strobe and channel to retire
//  irq_out               interrupt request to CPU
//  vec_out  [VEC_W-1:0]  presented channel index
//  in_service [NCH-1:0]  channels acked but not yet retired
//  pending  [NCH-1:0]    captured, not yet acked requests
//  dbg_state             FSM state, for status/debug
module irq_priority_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int VEC_W = VEC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   irq_req,
  input  logic [NCH-1:0]   irq_en,
  input  logic             irq_ack,
  input  logic             eoi,
  input  logic [VEC_W-1:0] eoi_id,
  output logic             irq_out,
  output logic [VEC_W-1:0] vec_out,
  output logic [NCH-1:0]   in_service,
  output logic [NCH-1:0]   pending,
  output irq_state_e       dbg_state
);

  irq_state_e       state_q, state_d;
  logic [NCH-1:0]   req_q;
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   in_service_q, in_service_d;
  logic             irq_out_q, irq_out_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  logic [NCH-1:0]   req_edge;
  logic [NCH-1:0]   gate;
  logic [NCH-1:0]   eligible;
  logic [NCH-1:0]   ack_set;
  logic [NCH-1:0]   eoi_clr;
  logic             win_valid;
  logic [VEC_W-1:0] win_idx;

  assign req_edge = irq_req & ~req_q;

`ifdef NESTING_EN
  // Ceiling = highest-priority in-service channel; only strictly
  // higher-priority (lower-index) channels may be presented.
  logic             ceil_valid;
  logic [VEC_W-1:0] ceil_idx;

  irq_prio_enc #(.NCH(NCH), .VEC_W(VEC_W)) u_ceil_enc (
    .req_i   (in_service_q),
    .valid_o (ceil_valid),
    .idx_o   (ceil_idx)
  );

  always_comb begin
    gate = '0;
    for (int i = 0; i < NCH; i++) begin
      gate[i] = !ceil_valid || (VEC_W'(i) < ceil_idx);
    end
  end
`else
  assign gate = {NCH{in_service_q == '0}};
`endif

  assign eligible = pending_q & irq_en & gate;

  irq_prio_enc #(.NCH(NCH), .VEC_W(VEC_W)) u_win_enc (
    .req_i   (eligible),
    .valid_o (win_valid),
    .idx_o   (win_idx)
  );

  // One-hot decode of eoi_id; ids >= NCH never match and channels not in
  // service are masked out, so both cases fall through as no-ops.
  always_comb begin
    eoi_clr = '0;
    for (int i = 0; i < NCH; i++) begin
      eoi_clr[i] = eoi && (eoi_id == VEC_W'(i)) && in_service_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    irq_out_d = irq_out_q;
    vec_d     = vec_q;
    ack_set   = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d   = ASSERT;
          irq_out_d = 1'b1;
          vec_d     = win_idx;
        end
      end
      ASSERT: begin
        // Enable changes do not withdraw a presented vector.
        if (irq_ack) begin
          for (int i = 0; i < NCH; i++) begin
            ack_set[i] = (vec_q == VEC_W'(i));
          end
          irq_out_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        irq_out_d = 1'b0;
      end
    endcase
  end

  // Set terms are ORed after clears: a new edge on the acked channel keeps
  // it pending, and an ack beats a same-cycle eoi on the same channel.
  assign pending_d    = (pending_q & ~ack_set) | req_edge;
  assign in_service_d = (in_service_q & ~eoi_clr) | ack_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_out_q    <= 1'b0;
      vec_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= irq_req;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_out_q    <= irq_out_d;
      vec_q        <= vec_d;
    end
  end

  assign irq_out    = irq_out_q;
  assign vec_out    = vec_q;
  assign in_service = in_service_q;
  assign pending    = pending_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Directed bench for irq_priority_ctrl: expected vectors are queued when a
// request is driven and popped when the controller presents irq_out.
module tb_irq_priority_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NCH   = 9;
  localparam int VEC_W = 4;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   irq_req;
  logic [NCH-1:0]   irq_en;
  logic             irq_ack;
  logic             eoi;
  logic [VEC_W-1:0] eoi_id;
  logic             irq_out;
  logic [VEC_W-1:0] vec_out;
  logic [NCH-1:0]   in_service;
  logic [NCH-1:0]   pending;
  irq_state_e       dbg_state;

  logic [VEC_W-1:0] exp_q[$];
  int               nvec = 0;
  int               nmis = 0;

  irq_priority_ctrl #(.NCH(NCH), .VEC_W(VEC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .irq_req    (irq_req),
    .irq_en     (irq_en),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .eoi_id     (eoi_id),
    .irq_out    (irq_out),
    .vec_out    (vec_out),
    .in_service (in_service),
    .pending    (pending),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_eoi(input logic [VEC_W-1:0] id);
    eoi    = 1'b1;
    eoi_id = id;
    tick();
    eoi    = 1'b0;
    eoi_id = '0;
  endtask

  // Bounded wait for irq_out, then compare vec_out to the queue head.
  task automatic wait_present(input string tag, output logic [VEC_W-1:0] exp_v);
    bit seen;
    bit have;
    seen  = 1'b0;
    exp_v = '0;
    for (int i = 0; i < 20; i++) begin
      if (irq_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    nvec++;
    assert (seen) else begin
      nmis++;
      $error("FAIL %s_timeout: observed irq_out=%0b expected 1", tag, irq_out);
    end
    if (seen) begin
      have = (exp_q.size() != 0);
      nvec++;
      assert (have) else begin
        nmis++;
        $error("FAIL %s_unexpected: observed vec %0d expected none", tag, vec_out);
      end
      if (have) begin
        exp_v = exp_q.pop_front();
        check({tag, "_vec"}, 32'(vec_out), 32'(exp_v));
      end
    end
  endtask

  // Present -> ack -> eoi for a channel expected to be the only one in service.
  task automatic serve_one(input string tag);
    logic [VEC_W-1:0] v;
    wait_present(tag, v);
    do_ack();
    check({tag, "_irq_drop"}, 32'(irq_out), 32'd0);
    check({tag, "_insvc"}, 32'(in_service), 32'(1) << v);
    do_eoi(v);
    check({tag, "_retired"}, 32'(in_service), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [VEC_W-1:0] v;
    rst_n   = 1'b0;
    irq_req = '0;
    irq_en  = '1;
    irq_ack = 1'b0;
    eoi     = 1'b0;
    eoi_id  = '0;
    ticks(2);
    check("rst_irq_out", 32'(irq_out), 32'd0);
    check("rst_vec", 32'(vec_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_insvc", 32'(in_service), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    ticks(2);

    // 1. single request on ch4, latency and handshake
    irq_req[4] = 1'b1;
    exp_q.push_back(4'd4);
    tick();
    check("t1_pending", 32'(pending), 32'h010);
    check("t1_no_irq_yet", 32'(irq_out), 32'd0);
    tick();
    check("t1_irq_latency", 32'(irq_out), 32'd1);
    wait_present("t1", v);
    ticks(2);
    check("t1_vec_stable", 32'(vec_out), 32'd4);
    do_ack();
    check("t1_irq_drop", 32'(irq_out), 32'd0);
    check("t1_insvc", 32'(in_service), 32'h010);
    check("t1_pending_clr", 32'(pending), 32'd0);
    irq_req[4] = 1'b0;
    do_eoi(4'd4);
    check("t1_retired", 32'(in_service), 32'd0);
    ticks(3);
    check("t1_level_no_reset", 32'(pending), 32'd0);

    // 2. simultaneous ch7, ch2, ch5
    irq_req = 9'h0A4;
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd5);
    exp_q.push_back(4'd7);
    tick();
    irq_req = '0;
    serve_one("t2a");
    serve_one("t2b");
    serve_one("t2c");
    check("t2_pending_empty", 32'(pending), 32'd0);

    // 3. masked channel stays pending, then wins once enabled
    irq_en[3]  = 1'b0;
    irq_req[3] = 1'b1;
    ticks(4);
    check("t3_masked_irq", 32'(irq_out), 32'd0);
    check("t3_masked_pend", 32'(pending), 32'h008);
    irq_req[3] = 1'b0;
    irq_en[3]  = 1'b1;
    exp_q.push_back(4'd3);
    tick();
    check("t3_enable_irq", 32'(irq_out), 32'd1);
    irq_en = '0;
    tick();
    check("t3_no_withdraw", 32'(irq_out), 32'd1);
    check("t3_no_withdraw_vec", 32'(vec_out), 32'd3);
    irq_en = '1;
    serve_one("t3");

    // 4. corner strobes
    do_ack();
    check("t4_idle_ack_state", 32'(dbg_state), 32'(IDLE));
    check("t4_idle_ack_insvc", 32'(in_service), 32'd0);
    do_eoi(4'd12);
    check("t4_eoi12_idle", 32'(in_service), 32'd0);
    irq_req[1] = 1'b1;
    exp_q.push_back(4'd1);
    wait_present("t4a", v);
    irq_req[1] = 1'b0;
    tick();
    irq_req[1] = 1'b1;
    irq_ack    = 1'b1;
    tick();
    irq_ack    = 1'b0;
    check("t4_set_wins_pend", 32'(pending), 32'h002);
    check("t4_acked_insvc", 32'(in_service), 32'h002);
    check("t4_held_irq", 32'(irq_out), 32'd0);
    do_eoi(4'd12);
    check("t4_eoi12_ignored", 32'(in_service), 32'h002);
    do_eoi(4'd3);
    check("t4_eoi_idle_ch", 32'(in_service), 32'h002);
    exp_q.push_back(4'd1);
    do_eoi(4'd1);
    check("t4_eoi1", 32'(in_service), 32'd0);
    irq_req[1] = 1'b0;
    serve_one("t4b");

    // eoi together with ack of the same channel: set wins
    irq_req[0] = 1'b1;
    exp_q.push_back(4'd0);
    wait_present("t4c", v);
    irq_req[0] = 1'b0;
    irq_ack    = 1'b1;
    eoi        = 1'b1;
    eoi_id     = 4'd0;
    tick();
    irq_ack    = 1'b0;
    eoi        = 1'b0;
    check("t4_ack_eoi_same", 32'(in_service), 32'h001);
    do_eoi(4'd0);
    check("t4_ack_eoi_clear", 32'(in_service), 32'd0);

    // 5. reset mid-handshake
    irq_req[6] = 1'b1;
    exp_q.push_back(4'd6);
    wait_present("t5", v);
    rst_n   = 1'b0;
    irq_req = '0;
    tick();
    rst_n = 1'b1;
    check("t5_irq", 32'(irq_out), 32'd0);
    check("t5_vec", 32'(vec_out), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);
    check("t5_insvc", 32'(in_service), 32'd0);
    check("t5_state", 32'(dbg_state), 32'(IDLE));
    ticks(5);
    check("t5_no_represent", 32'(irq_out), 32'd0);

    // 6. ch5 in service, then ch1 and ch8 edges
    irq_req[5] = 1'b1;
    exp_q.push_back(4'd5);
    wait_present("t6a", v);
    irq_req[5] = 1'b0;
    do_ack();
    check("t6_insvc5", 32'(in_service), 32'h020);
    irq_req = 9'h102;
    tick();
    irq_req = '0;
`ifdef NESTING_EN
    exp_q.push_back(4'd1);
    wait_present("t6b", v);
    do_ack();
    check("t6_nest_insvc", 32'(in_service), 32'h022);
    ticks(3);
    check("t6_ch8_held", 32'(irq_out), 32'd0);
    do_eoi(4'd1);
    ticks(3);
    check("t6_ch8_still_held", 32'(irq_out), 32'd0);
    exp_q.push_back(4'd8);
    do_eoi(4'd5);
    serve_one("t6c");
`else
    ticks(4);
    check("t6_no_preempt", 32'(irq_out), 32'd0);
    check("t6_pending", 32'(pending), 32'h102);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd8);
    do_eoi(4'd5);
    serve_one("t6b");
    serve_one("t6c");
`endif

    ticks(3);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_irq_idle", 32'(irq_out), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
